phase_scheduler: RTL and testbench
==================================

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter T_YEL, default 2: yellow duration in clock cycles.
REQ-002 Parameter T_CLR, default 1: all-red clearance duration in clock cycles.
REQ-003 Parameter CW, default 4: width of green-duration counter and green_len input.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port req  input  4  per-approach demand, level; bit0=M1, bit1=M2, bit2=MT, bit3=ST.
REQ-007 Port emg_valid  input  1  emergency preempt request, level.
REQ-008 Port emg_dir  input  2  approach index for emergency (0=M1,1=M2,2=MT,3=ST).
REQ-009 Port green_len  input  CW  green duration in cycles; sampled on GREEN entry.
REQ-010 Port light_M1, light_M2, light_MT, light_ST  output  3 each  lamp code: 100 red, 010 yellow, 001 green.
REQ-011 Port grant  output  2  index of approach currently served (valid when busy=1).
REQ-012 Port busy  output  1  high in GREEN, YELLOW, CLEAR.

Function
REQ-013 FSM states SHALL be IDLE, GREEN, YELLOW, CLEAR; outputs registered, one-hot lamp codes only.
REQ-014 pending[3:0] SHALL set on req bit high, clear only on the cycle its approach enters GREEN (set wins if same approach's req still high next cycle).
REQ-015 IDLE: all lamps 100; on pending!=0 or emg_valid, next cycle enters GREEN for selected approach.
REQ-016 Selection: emg_valid wins with emg_dir; else round-robin over pending starting at last_grant+1 mod 4; last_grant resets to 3 (M1 first).
REQ-017 GREEN: served lamp 001, others 100; lasts max(green_len,1) cycles, green_len latched at entry.
REQ-018 GREEN extension: if emg_valid with emg_dir==grant, green holds (counter frozen) until emg_valid drops.
REQ-019 Preemption: emg_valid with emg_dir!=grant during GREEN SHALL force YELLOW on the next cycle regardless of counter.
REQ-020 YELLOW: served lamp 010, others 100, exactly T_YEL cycles; no preemption shortens it.
REQ-021 CLEAR: all 100 for T_CLR cycles; then GREEN for next selection if pending!=0 or emg_valid, else IDLE.
REQ-022 Never more than one approach non-red in any cycle; GREEN never directly follows GREEN.
REQ-023 emg_dir changing mid-preempt: selection uses emg_dir value at CLEAR exit.
REQ-024 Counters saturate-free: compare-then-reset at terminal count; no wrap beyond CW bits.

Reset
REQ-025 On rst=1 at clk edge: state=IDLE, all lamps 100, grant=0, busy=0, pending=0, counter=0, last_grant=3.
REQ-026 Reset mid-GREEN/YELLOW SHALL go straight to all-red next cycle, no yellow.
REQ-027 req/emg_valid sampled in reset cycle SHALL be discarded.

Structure
REQ-028 Shared package SHALL hold lamp codes (RED=100, YEL=010, GRN=001), approach indices, FSM state enum.
REQ-029 Round-robin selection SHALL be sub-module rr_arb4 (inputs pending, last_grant; outputs any, idx), combinational.
REQ-030 Target size 150-300 lines RTL; no latches; single always_ff for state/counters.

Verification
REQ-031 Reset then req=0010, green_len=3 -> GREEN M2 for 3 cycles, YELLOW 2, CLEAR 1, IDLE; M2 lamps 001,010,100.
REQ-032 req=1111 held, green_len=2 -> grant order 0,1,2,3,0 with 5-cycle gaps (2+2+1).
REQ-033 M1 in GREEN cycle 1 of 5, emg_valid=1 emg_dir=3 -> YELLOW next cycle, CLEAR, then GREEN ST.
REQ-034 ST GREEN with emg_valid=1 emg_dir=3 held 10 cycles, green_len=2 -> ST green 10+ cycles, then YELLOW after drop.
REQ-035 rst pulsed during YELLOW of MT -> next cycle all lamps 100, busy=0, pending=0.
REQ-036 green_len=0, req=0001 -> GREEN M1 exactly 1 cycle; assertion: at most one non-red lamp every cycle.

Source files
------------

// File: rtl/phase_scheduler_pkg.sv
// Shared lamp codes, approach indices and FSM states
// for the four-approach phase scheduler.
package phase_scheduler_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [1:0] AP_M1 = 2'd0;
  localparam logic [1:0] AP_M2 = 2'd1;
  localparam logic [1:0] AP_MT = 2'd2;
  localparam logic [1:0] AP_ST = 2'd3;

  localparam logic [11:0] ALL_RED = {4{RED}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_CLEAR
  } state_t;

  // All lamps red except the served approach.
  function automatic logic [11:0] lamp_set(
    input logic [1:0] idx,
    input logic [2:0] code
  );
    logic [11:0] v;
    v = ALL_RED;
    v[3*int'(idx) +: 3] = code;
    return v;
  endfunction

endpackage

// File: rtl/phase_scheduler_rr_arb4.sv
// Four-way round-robin pick over pending demand,
// searching from the approach after last_grant.
module rr_arb4 (
  input  logic [3:0] pending,
  input  logic [1:0] last_grant,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] c;

  // Scan far-to-near so the nearest pending approach wins.
  always_comb begin
    any = |pending;
    idx = last_grant;
    c   = '0;
    for (int i = 4; i >= 1; i--) begin
      c = last_grant + 2'(i);
      if (pending[c]) idx = c;
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Four-approach signal phase scheduler with
// round-robin service and emergency preemption.
module phase_scheduler
  import phase_scheduler_pkg::*;
#(
  parameter int T_YEL = 2,
  parameter int T_CLR = 1,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic          emg_valid,
  input  logic [1:0]    emg_dir,
  input  logic [CW-1:0] green_len,
  output logic [2:0]    light_M1,
  output logic [2:0]    light_M2,
  output logic [2:0]    light_MT,
  output logic [2:0]    light_ST,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int TMAX = (T_YEL > T_CLR) ? T_YEL : T_CLR;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int NW   = (CW > TW) ? CW : TW;

  state_t        state;
  logic [11:0]   lamps;
  logic [1:0]    last_grant;
  logic [3:0]    pending;
  logic [NW-1:0] cnt;
  logic [CW-1:0] glen;

  logic          arb_any;
  logic [1:0]    arb_idx;
  logic          sel_any;
  logic [1:0]    sel_idx;
  logic [3:0]    sel_mask;
  logic          hold;
  logic          preempt;
  logic          g_last;
  logic          y_done;
  logic          c_done;
  logic          start;

  rr_arb4 u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .any        (arb_any),
    .idx        (arb_idx)
  );

  assign sel_any  = emg_valid | arb_any;
  assign sel_idx  = emg_valid ? emg_dir : arb_idx;
  assign sel_mask = 4'b0001 << sel_idx;

  assign hold    = emg_valid && (emg_dir == grant);
  assign preempt = emg_valid && (emg_dir != grant);
  assign g_last  = cnt == (NW'(glen) - NW'(1));
  assign y_done  = cnt == NW'(T_YEL - 1);
  assign c_done  = cnt == NW'(T_CLR - 1);

  assign start = sel_any &&
                 ((state == S_IDLE) ||
                  ((state == S_CLEAR) && c_done));

  assign light_M1 = lamps[2:0];
  assign light_M2 = lamps[5:3];
  assign light_MT = lamps[8:6];
  assign light_ST = lamps[11:9];

  // Phase FSM, phase counter, demand latch and lamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lamps      <= ALL_RED;
      grant      <= AP_M1;
      busy       <= 1'b0;
      pending    <= '0;
      cnt        <= '0;
      glen       <= CW'(1);
      last_grant <= AP_ST;
    end else begin
      pending <= (pending | req) &
                 ~(start ? sel_mask : 4'b0000);
      if (start) begin
        state      <= S_GREEN;
        grant      <= sel_idx;
        last_grant <= sel_idx;
        cnt        <= '0;
        glen       <= (green_len == '0) ? CW'(1)
                                        : green_len;
        busy       <= 1'b1;
        lamps      <= lamp_set(sel_idx, GRN);
      end else begin
        unique case (state)
          S_IDLE: begin
            busy  <= 1'b0;
            lamps <= ALL_RED;
          end
          S_GREEN: begin
            if (preempt || (!hold && g_last)) begin
              state <= S_YELLOW;
              cnt   <= '0;
              lamps <= lamp_set(grant, YEL);
            end else if (!hold) begin
              cnt <= cnt + NW'(1);
            end
          end
          S_YELLOW: begin
            if (y_done) begin
              state <= S_CLEAR;
              cnt   <= '0;
              lamps <= ALL_RED;
            end else begin
              cnt <= cnt + NW'(1);
            end
          end
          S_CLEAR: begin
            if (c_done) begin
              state <= S_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              lamps <= ALL_RED;
            end else begin
              cnt <= cnt + NW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed and randomized checks of phase_scheduler
// against a cycle-level behavioural model.
module tb_phase_scheduler;

  localparam int T_YEL = 2;
  localparam int T_CLR = 1;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic          emg_valid;
  logic [1:0]    emg_dir;
  logic [CW-1:0] green_len;
  logic [2:0]    light_M1;
  logic [2:0]    light_M2;
  logic [2:0]    light_MT;
  logic [2:0]    light_ST;
  logic [1:0]    grant;
  logic          busy;

  phase_scheduler #(
    .T_YEL (T_YEL),
    .T_CLR (T_CLR),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .emg_valid (emg_valid),
    .emg_dir   (emg_dir),
    .green_len (green_len),
    .light_M1  (light_M1),
    .light_M2  (light_M2),
    .light_MT  (light_MT),
    .light_ST  (light_ST),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef enum {M_IDLE, M_GREEN, M_YELLOW, M_CLEAR} mph_t;
  mph_t     m_ph;
  int       m_grant;
  int       m_last;
  int       m_rem;
  bit [3:0] m_pend;

  string names [4] = '{"M1", "M2", "MT", "ST"};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int rr(input bit [3:0] p,
                            input int last);
    for (int k = 1; k <= 4; k++) begin
      if (p[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_lamp(input int a);
    if (m_ph == M_GREEN && a == m_grant) return 3'b001;
    if (m_ph == M_YELLOW && a == m_grant) return 3'b010;
    return 3'b100;
  endfunction

  // Apply the scheduling rules to the inputs seen at this edge.
  task automatic model_edge();
    bit [3:0] np;
    bit       go;
    int       g;
    if (rst) begin
      m_ph = M_IDLE; m_grant = 0; m_last = 3;
      m_pend = '0; m_rem = 0;
      return;
    end
    np = m_pend | req;
    go = 1'b0;
    case (m_ph)
      M_IDLE:
        go = (m_pend != 0) || emg_valid;
      M_GREEN:
        if (emg_valid && int'(emg_dir) != m_grant) begin
          m_ph = M_YELLOW; m_rem = T_YEL;
        end else if (!emg_valid) begin
          m_rem--;
          if (m_rem == 0) begin
            m_ph = M_YELLOW; m_rem = T_YEL;
          end
        end
      M_YELLOW: begin
        m_rem--;
        if (m_rem == 0) begin
          m_ph = M_CLEAR; m_rem = T_CLR;
        end
      end
      M_CLEAR: begin
        m_rem--;
        if (m_rem == 0) begin
          if ((m_pend != 0) || emg_valid) go = 1'b1;
          else m_ph = M_IDLE;
        end
      end
    endcase
    if (go) begin
      g = emg_valid ? int'(emg_dir) : rr(m_pend, m_last);
      m_ph = M_GREEN; m_grant = g; m_last = g;
      m_rem = (green_len == 0) ? 1 : int'(green_len);
      np[g] = 1'b0;
    end
    m_pend = np;
  endtask

  task automatic step();
    logic [2:0] lv [4];
    int nonred;
    bit onehot;
    @(posedge clk);
    model_edge();
    #1;
    lv[0] = light_M1; lv[1] = light_M2;
    lv[2] = light_MT; lv[3] = light_ST;
    nonred = 0;
    onehot = 1'b1;
    for (int a = 0; a < 4; a++) begin
      check($sformatf("lamp_%s", names[a]),
            32'(lv[a]), 32'(exp_lamp(a)));
      if (lv[a] !== 3'b100) nonred++;
      if ($countones(lv[a]) != 1) onehot = 1'b0;
    end
    check("busy", 32'(busy), 32'(m_ph != M_IDLE));
    if (m_ph != M_IDLE)
      check("grant", 32'(grant), 32'(m_grant));
    check("exclusive", 32'(nonred <= 1 && onehot), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] m2_exp [7];
    logic       bz_exp [7];
    int         gq [$];
    int         tq [$];
    int         cyc;
    bit         prev_g;
    int         gcnt;
    bit         seen;

    rst = 1'b1; req = '0; emg_valid = 1'b0;
    emg_dir = '0; green_len = '0;

    // Reset, with demand and emergency present in the reset cycle.
    step();
    req = 4'b1111; emg_valid = 1'b1; emg_dir = 2'd2;
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lamps",
          32'({light_M1, light_M2, light_MT, light_ST}),
          32'(12'b100100100100));
    rst = 1'b0; req = '0; emg_valid = 1'b0;
    step();
    step();
    check("rst_discard", 32'(busy), 32'd0);

    // Single M2 request with green_len 3.
    green_len = 4'd3; req = 4'b0010;
    step();
    req = '0;
    m2_exp[0] = 3'b001; m2_exp[1] = 3'b001;
    m2_exp[2] = 3'b001; m2_exp[3] = 3'b010;
    m2_exp[4] = 3'b010; m2_exp[5] = 3'b100;
    m2_exp[6] = 3'b100;
    bz_exp[0] = 1; bz_exp[1] = 1; bz_exp[2] = 1;
    bz_exp[3] = 1; bz_exp[4] = 1; bz_exp[5] = 1;
    bz_exp[6] = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("m2_seq%0d", i),
            32'(light_M2), 32'(m2_exp[i]));
      check($sformatf("m2_busy%0d", i),
            32'(busy), 32'(bz_exp[i]));
    end

    // All four requesting: round-robin order from reset.
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; green_len = 4'd2;
    prev_g = 1'b0;
    for (int i = 0; i < 40 && gq.size() < 5; i++) begin
      step();
      seen = busy &&
             ((grant == 2'd0 && light_M1 == 3'b001) ||
              (grant == 2'd1 && light_M2 == 3'b001) ||
              (grant == 2'd2 && light_MT == 3'b001) ||
              (grant == 2'd3 && light_ST == 3'b001));
      if (seen && !prev_g) begin
        gq.push_back(int'(grant));
        tq.push_back(i);
      end
      prev_g = seen;
    end
    check("rr_entries", 32'(gq.size()), 32'd5);
    for (int k = 0; k < gq.size(); k++) begin
      check($sformatf("rr_order%0d", k),
            32'(gq[k]), 32'(k % 4));
      if (k > 0)
        check($sformatf("rr_gap%0d", k),
              32'(tq[k] - tq[k-1]), 32'd5);
    end
    req = '0;
    for (int i = 0; i < 60 && m_ph != M_IDLE; i++) step();

    // Preempt M1 green by ST emergency, then extend ST green.
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0001; green_len = 4'd5;
    step();
    req = '0;
    step();
    check("pre_m1_green", 32'(light_M1), 32'(3'b001));
    green_len = 4'd2;
    emg_valid = 1'b1; emg_dir = 2'd3;
    step();
    check("pre_m1_yellow", 32'(light_M1), 32'(3'b010));
    step();
    step();
    check("pre_clear", 32'(light_M1), 32'(3'b100));
    step();
    check("pre_st_grant", 32'(grant), 32'd3);
    check("pre_st_green", 32'(light_ST), 32'(3'b001));
    gcnt = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (light_ST == 3'b001) gcnt++;
    end
    emg_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (light_ST != 3'b001) break;
      gcnt++;
    end
    check("ext_st_len", 32'(gcnt), 32'd12);
    check("ext_st_yellow", 32'(light_ST), 32'(3'b010));
    for (int i = 0; i < 20 && m_ph != M_IDLE; i++) step();

    // Reset during MT yellow goes straight to all red.
    req = 4'b0100; green_len = 4'd1;
    step();
    req = '0;
    step();
    check("mt_green", 32'(light_MT), 32'(3'b001));
    step();
    check("mt_yellow", 32'(light_MT), 32'(3'b010));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mt_rst_red", 32'(light_MT), 32'(3'b100));
    check("mt_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    check("mt_rst_idle", 32'(busy), 32'd0);

    // green_len 0 behaves as a single green cycle.
    green_len = 4'd0; req = 4'b0001;
    step();
    req = '0;
    step();
    check("gl0_green", 32'(light_M1), 32'(3'b001));
    step();
    check("gl0_yellow", 32'(light_M1), 32'(3'b010));
    for (int i = 0; i < 10 && m_ph != M_IDLE; i++) step();

    // Randomized traffic against the model.
    cyc = 0;
    repeat (600) begin
      rst = ($urandom_range(0, 99) == 0);
      req = ($urandom_range(0, 3) == 0)
            ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 24) == 0)
        emg_valid = ~emg_valid;
      if ($urandom_range(0, 7) == 0)
        emg_dir = 2'($urandom_range(0, 3));
      green_len = CW'($urandom_range(0, 5));
      step();
      cyc++;
    end
    rst = 1'b0; req = '0; emg_valid = 1'b0;
    for (int i = 0; i < 60 && m_ph != M_IDLE; i++) step();
    step();
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
